req_encode8: RTL and testbench

Eight-way request encoder/arbiter for the register-file write path: the inverse direction of the 3-to-8 write-select decoder. It samples eight request lines, picks one winner, and presents it as a registered 3-bit index plus matching one-hot grant under a valid/ready handshake. Each grant is held until the consumer accepts it. Round-robin fairness is a compile-time option.

---
 rtl/req_encode8_if.sv | 28 ++
 rtl/req_encode8.sv | 111 +++++++++++
 tb/tb_req_encode8.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/req_encode8_if.sv
// Handshake bundle between the request encoder and its consumer.
// The slave modport is the encoder's view; the master modport is the requester/consumer side.
interface req_encode8_if;
  logic       enable;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] grant;

  modport slave (
    input  enable,
    input  req,
    input  ready,
    output valid,
    output idx,
    output grant
  );

  modport master (
    output enable,
    output req,
    output ready,
    input  valid,
    input  idx,
    input  grant
  );
endinterface

// File: rtl/req_encode8.sv
// req_encode8: eight-way request encoder/arbiter with a registered index and one-hot grant
// under a valid/ready handshake. A committed grant is held until the consumer accepts it.
// Build option: define REQ_ENCODE8_ROUND_ROBIN_EN for round-robin selection; otherwise the
// lowest requesting index wins and no rotation pointer exists.
module req_encode8 (
  input logic          clk,
  input logic          rst_n,
  req_encode8_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q;
  logic       valid_q;
  logic [2:0] idx_q;
  logic [7:0] grant_q;
  logic [2:0] win_d;
  logic       any_req;

  assign any_req = |bus.req;

`ifdef REQ_ENCODE8_ROUND_ROBIN_EN
  logic [2:0] ptr_q;
  logic [2:0] start_d;

  // First set request scanning upward from s, wrapping 7 -> 0.
  function automatic logic [2:0] pick_rr(input logic [7:0] r, input logic [2:0] s);
    logic [2:0] j;
    logic       found;
    pick_rr = s;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      j = s + 3'(k);
      if (!found && r[j]) begin
        pick_rr = j;
        found   = 1'b1;
      end
    end
  endfunction

  // In HOLD a new pick only happens on acceptance, where the pointer is about to become idx+1,
  // so scan from there directly rather than from the stale pointer.
  always_comb begin
    start_d = (state_q == HOLD) ? (idx_q + 3'd1) : ptr_q;
    win_d   = pick_rr(bus.req, start_d);
  end
`else
  // Lowest set request index.
  function automatic logic [2:0] pick_fixed(input logic [7:0] r);
    pick_fixed = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (r[k]) pick_fixed = 3'(k);
    end
  endfunction

  // Fixed-priority winner from the live request lines.
  always_comb begin
    win_d = pick_fixed(bus.req);
  end
`endif

  // Two-state handshake FSM with registered valid/idx/grant (and rotation pointer when enabled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= 3'd0;
      grant_q <= 8'h00;
`ifdef REQ_ENCODE8_ROUND_ROBIN_EN
      ptr_q   <= 3'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable && any_req) begin
            idx_q   <= win_d;
            grant_q <= 8'h01 << win_d;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Frozen until accepted; req/enable changes are ignored while ready is low.
          if (bus.ready) begin
`ifdef REQ_ENCODE8_ROUND_ROBIN_EN
            ptr_q <= idx_q + 3'd1;
`endif
            if (bus.enable && any_req) begin
              idx_q   <= win_d;
              grant_q <= 8'h01 << win_d;
            end else begin
              valid_q <= 1'b0;
              grant_q <= 8'h00;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          grant_q <= 8'h00;
        end
      endcase
    end
  end

  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.grant = grant_q;

endmodule

// File: tb/tb_req_encode8.sv
// Self-checking bench for req_encode8: directed scenarios plus randomized traffic checked
// against a behavioural model of the arbitration rules.
module tb_req_encode8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  req_encode8_if bus ();

  req_encode8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  bit m_valid;
  int m_idx;
  int m_ptr;

`ifdef REQ_ENCODE8_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_grant();
    logic [7:0] g;
    g = 8'h00;
    if (m_valid) g[m_idx] = 1'b1;
    return g;
  endfunction

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    bit         en;
    bit         rdy;
    logic [7:0] r;
    en  = bus.enable;
    rdy = bus.ready;
    r   = bus.req;
    @(posedge clk);
    if (!m_valid) begin
      if (en && r != 8'h00) begin
        m_idx   = pick(r, RR ? m_ptr : 0);
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % 8;
      if (en && r != 8'h00) m_idx = pick(r, RR ? m_ptr : 0);
      else m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.req    = 8'h00;
    bus.ready  = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    bus.enable = 1'b1;
    bus.req    = 8'h10;
    tick();
    n_cmp++;
    if (bus.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_valid: got %b want 1", bus.valid);
    end
    // Async assertion mid-cycle while a grant is held
    #2;
    rst_n = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    #1;
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.grant !== 8'h00 || bus.idx !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b idx=%0d g=%h want v=0 idx=0 g=00",
               bus.valid, bus.idx, bus.grant);
    end
    bus.req = 8'h00;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.grant !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_idle_after: got v=%b g=%h want v=0 g=00", bus.valid, bus.grant);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 8'h20;
    bus.ready  = 1'b0;
    tick();
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.idx !== 3'd5 || bus.grant !== 8'h20) begin
      n_bad++;
      $display("FAIL single_grant: got v=%b idx=%0d g=%h want v=1 idx=5 g=20",
               bus.valid, bus.idx, bus.grant);
    end
    bus.req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.idx !== 3'd5 || bus.grant !== 8'h20) begin
        n_bad++;
        $display("FAIL single_hold%0d: got v=%b idx=%0d g=%h want v=1 idx=5 g=20",
                 i, bus.valid, bus.idx, bus.grant);
      end
    end
    bus.ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.grant !== 8'h00 || bus.idx !== 3'd5) begin
      n_bad++;
      $display("FAIL single_accept: got v=%b idx=%0d g=%h want v=0 idx=5 g=00",
               bus.valid, bus.idx, bus.grant);
    end
    bus.ready = 1'b0;
  endtask

`ifdef REQ_ENCODE8_ROUND_ROBIN_EN
  task automatic test_rotation();
    int exp_a[9];
    int exp_b[4];
    exp_a = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    exp_b = '{0, 7, 0, 7};
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 8'hFF;
    bus.ready  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.idx !== 3'(exp_a[i])) begin
        n_bad++;
        $display("FAIL rr_ff_step%0d: got v=%b idx=%0d want v=1 idx=%0d",
                 i, bus.valid, bus.idx, exp_a[i]);
      end
    end
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 8'h81;
    bus.ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.idx !== 3'(exp_b[i])) begin
        n_bad++;
        $display("FAIL rr_81_step%0d: got v=%b idx=%0d want v=1 idx=%0d",
                 i, bus.valid, bus.idx, exp_b[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 8'h80;
    bus.ready  = 1'b0;
    tick();
    n_cmp++;
    if (bus.idx !== 3'd7 || bus.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_first: got v=%b idx=%0d want v=1 idx=7", bus.valid, bus.idx);
    end
    bus.req   = 8'h88;
    bus.ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.idx !== 3'd3 || bus.grant !== 8'h08 || bus.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_next: got v=%b idx=%0d g=%h want v=1 idx=3 g=08",
               bus.valid, bus.idx, bus.grant);
    end
    bus.ready = 1'b0;
  endtask
`else
  task automatic test_fixed();
    do_reset();
    bus.enable = 1'b1;
    bus.req    = 8'h81;
    bus.ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.idx !== 3'd0 || bus.grant !== 8'h01) begin
        n_bad++;
        $display("FAIL fixed_step%0d: got v=%b idx=%0d g=%h want v=1 idx=0 g=01",
                 i, bus.valid, bus.idx, bus.grant);
      end
    end
    bus.req = 8'hA8;
    tick();
    n_cmp++;
    if (bus.idx !== 3'd3 || bus.valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fixed_lowest: got v=%b idx=%0d want v=1 idx=3", bus.valid, bus.idx);
    end
    bus.ready = 1'b0;
  endtask
`endif

  task automatic test_enable_gating();
    do_reset();
    bus.enable = 1'b0;
    bus.req    = 8'h04;
    bus.ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b0 || bus.grant !== 8'h00) begin
        n_bad++;
        $display("FAIL en_block%0d: got v=%b g=%h want v=0 g=00", i, bus.valid, bus.grant);
      end
    end
    bus.enable = 1'b1;
    tick();
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.idx !== 3'd2) begin
      n_bad++;
      $display("FAIL en_grant: got v=%b idx=%0d want v=1 idx=2", bus.valid, bus.idx);
    end
    bus.enable = 1'b0;
    tick();
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.grant !== 8'h04) begin
      n_bad++;
      $display("FAIL en_hold: got v=%b g=%h want v=1 g=04", bus.valid, bus.grant);
    end
    bus.req   = 8'h08;
    bus.ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.grant !== 8'h00) begin
      n_bad++;
      $display("FAIL en_accept: got v=%b g=%h want v=0 g=00", bus.valid, bus.grant);
    end
    tick();
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL en_no_regrant: got v=%b want 0", bus.valid);
    end
    bus.ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] eg;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.ready  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: bus.req = 8'h00;
        1: bus.req = 8'h01 << $urandom_range(0, 7);
        default: bus.req = 8'($urandom);
      endcase
      tick();
      eg = exp_grant();
      n_cmp++;
      if (bus.valid !== m_valid || bus.grant !== eg || (m_valid && bus.idx !== 3'(m_idx))) begin
        n_bad++;
        $display("FAIL random_cyc%0d: got v=%b idx=%0d g=%h want v=%b idx=%0d g=%h",
                 i, bus.valid, bus.idx, bus.grant, m_valid, m_idx, eg);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.req    = 8'h00;
    bus.ready  = 1'b0;
    m_valid    = 1'b0;
    m_idx      = 0;
    m_ptr      = 0;
    #3;
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.idx !== 3'd0 || bus.grant !== 8'h00) begin
      n_bad++;
      $display("FAIL power_on_reset: got v=%b idx=%0d g=%h want v=0 idx=0 g=00",
               bus.valid, bus.idx, bus.grant);
    end
    rst_n = 1'b1;
    test_reset();
    test_single();
`ifdef REQ_ENCODE8_ROUND_ROBIN_EN
    test_rotation();
    test_wrap();
`else
    test_fixed();
`endif
    test_enable_gating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
